instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 9, instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 512, instruction-memory depth in 32-bit words (2**ADDR_W).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 len  input  10  number of 32-bit words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-008 in_data  input  8  stream byte.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 wr_addr  output  ADDR_W  word address for the write.
REQ-012 wr_data  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress; fetch stage holds its address register while high.
REQ-014 done  output  1  one-cycle pulse at load completion.

Function
REQ-015 FSM states: IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: in_ready=0, busy=0; start=1 -> latch min(len,DEPTH) as target, clear word counter and byte index; go to LOAD, or to DONE if target=0.
REQ-017 A byte transfers only when in_valid=1 and in_ready=1 in the same cycle. in_ready is 1 only in LOAD.
REQ-018 Byte order is little-endian: byte 0 goes to bits 7:0 and byte 3 goes to bits 31:24.
REQ-019 LOAD: transfer of byte index 3 -> go to WRITE on the next edge. Otherwise the byte index increments by 1 (2-bit counter).
REQ-020 WRITE: wr_en=1 for exactly one cycle, wr_addr=word counter, wr_data=assembled word, in_ready=0.
REQ-021 Write latency: wr_en is asserted in the cycle after the 4th byte transfer.
REQ-022 After WRITE: word counter increments. If it equals the target, go to DONE; otherwise return to LOAD with byte index 0.
REQ-023 Word counter is 10 bits. wr_addr is its low ADDR_W bits, and no address beyond DEPTH-1 is written.
REQ-024 DONE: done=1 for one cycle, then return to IDLE. busy=1 in LOAD, WRITE and DONE.
REQ-025 start outside IDLE is ignored. in_valid outside LOAD is ignored, and no byte is consumed.
REQ-026 in_valid gaps in LOAD stall assembly indefinitely; no timeout.
REQ-027 wr_en, in_ready and done are never high while rst_n=0.

Reset
REQ-028 rst_n low at any time (including mid-word or mid-write) -> IDLE immediately.
REQ-029 Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, counters=0.
REQ-030 A partial word in progress at reset is discarded; words already written stay in memory.

Structure
REQ-031 A shared package holds the FSM state encoding, INSTR_W=32, BYTES_PER_INSTR=4 and the default ADDR_W.
REQ-032 One sub-module, byte_packer, contains the 2-bit byte index and the 32-bit shift/assembly register, with outputs word and word_full.
REQ-033 Outputs wr_en, wr_addr, wr_data and done are registered.

Verification
REQ-034 start with len=1; bytes 0x13,0x00,0x10,0x00 sent back-to-back -> one wr_en, wr_addr=0, wr_data=0x00100013, done one cycle later, busy falls after DONE.
REQ-035 len=3 with in_valid toggling every other cycle -> writes at addresses 0,1,2 in order, each exactly one cycle after its 4th byte transfer, and in_ready=0 during every WRITE cycle.
REQ-036 len=0 -> DONE immediately, done pulses once, no wr_en, in_ready stays 0.
REQ-037 len=600 -> exactly 512 writes; the last is at wr_addr=511; no write wraps to address 0.
REQ-038 rst_n asserted after 2 bytes of word 5 -> outputs at reset values asynchronously; a new start reloads from address 0.
REQ-039 start pulsed during LOAD, and in_valid held high in IDLE -> both ignored; the target and word count of the active load are unchanged.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and sizing for the instruction-memory byte-stream loader.
package instr_loader_pkg;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned IDX_W           = 2;
    localparam int unsigned LEN_W           = 10;
    localparam int unsigned DEF_ADDR_W      = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles four stream bytes little-endian into one instruction word.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 take,
    input  logic [BYTE_W-1:0]    data,
    output logic [INSTR_W-1:0]   word,
    output logic                 word_full
);

    logic [IDX_W-1:0]          idx;
    logic [INSTR_W-BYTE_W-1:0] sr;

    // The incoming byte lands on top, so after four bytes byte 0 sits in bits 7:0.
    assign word      = {data, sr};
    assign word_full = take && (idx == IDX_W'(BYTES_PER_INSTR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            sr  <= '0;
        end else if (clr) begin
            idx <= '0;
            sr  <= '0;
        end else if (take) begin
            idx <= idx + IDX_W'(1);
            sr  <= word[INSTR_W-1:BYTE_W];
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a little-endian byte stream into instruction memory, one word write per four bytes.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 512
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                busy,
    output logic                done
);

    state_e               state;
    state_e               state_nxt;
    logic [LEN_W-1:0]     target;
    logic [LEN_W-1:0]     cnt;
    logic [LEN_W-1:0]     cnt_inc;
    logic [LEN_W-1:0]     len_clip;
    logic                 take;
    logic                 clr;
    logic [INSTR_W-1:0]   word;
    logic                 word_full;

    // Clamping the target to DEPTH keeps every write address inside memory.
    assign len_clip = (32'(len) > DEPTH) ? LEN_W'(DEPTH) : len;
    assign cnt_inc  = cnt + LEN_W'(1);
    assign take     = in_valid && in_ready;
    assign clr      = (state == S_IDLE) && start;

    instr_loader_byte_packer u_byte_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .take      (take),
        .data      (in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len_clip == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (word_full) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = (cnt_inc == target) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            target   <= '0;
            cnt      <= '0;
        end else begin
            in_ready <= (state_nxt == S_LOAD);
            busy     <= (state_nxt != S_IDLE);
            wr_en    <= (state_nxt == S_WRITE);
            done     <= (state_nxt == S_DONE);
            if (clr) begin
                target <= len_clip;
                cnt    <= '0;
            end
            if (state == S_WRITE) begin
                cnt <= cnt_inc;
            end
            if (state == S_LOAD && word_full) begin
                wr_data <= word;
                wr_addr <= cnt[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a byte-counting reference model.
module tb_instr_loader;

    localparam int DEPTH_TB = 512;
    localparam int BOUND    = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: what the DUT must present in the current cycle.
    bit          m_active = 1'b0;
    bit          m_ready  = 1'b0;
    bit          m_wen    = 1'b0;
    bit          m_done   = 1'b0;
    int          m_tgt    = 0;
    int          m_bytes  = 0;
    int          m_waddr  = 0;
    logic [31:0] m_word   = '0;
    logic [31:0] m_wdata  = '0;

    int          obs_writes = 0;
    int          obs_dones  = 0;
    int          obs_last_addr = 0;
    logic [31:0] obs_last_data = '0;

    instr_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the model, using the inputs held across that edge.
    task automatic model_edge();
        bit nw = 1'b0;
        bit nd = 1'b0;
        if (!m_active && !m_done && start) begin
            m_tgt   = (int'(len) > DEPTH_TB) ? DEPTH_TB : int'(len);
            m_bytes = 0;
            m_word  = '0;
            if (m_tgt == 0) nd = 1'b1;
            else            m_active = 1'b1;
        end
        if (m_ready && in_valid) begin
            m_word  = m_word | (32'(in_data) << (8 * (m_bytes % 4)));
            m_bytes = m_bytes + 1;
            if (m_bytes % 4 == 0) begin
                nw      = 1'b1;
                m_wdata = m_word;
                m_waddr = m_bytes / 4 - 1;
                m_word  = '0;
            end
        end
        if (m_wen && m_bytes == 4 * m_tgt) begin
            m_active = 1'b0;
            nd       = 1'b1;
        end
        m_wen   = nw;
        m_done  = nd;
        m_ready = m_active && !nw && !nd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("wr_en",    32'(wr_en),    32'(m_wen));
        check("done",     32'(done),     32'(m_done));
        check("busy",     32'(busy),     32'(m_active || m_done));
        if (m_wen) begin
            check("wr_addr", 32'(wr_addr), 32'(m_waddr));
            check("wr_data", wr_data,      m_wdata);
        end
        if (wr_en) begin
            obs_writes++;
            obs_last_addr = int'(wr_addr);
            obs_last_data = wr_data;
        end
        if (done) obs_dones++;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  wr_data,       32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        m_active = 1'b0;
        m_ready  = 1'b0;
        m_wen    = 1'b0;
        m_done   = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        check("rst_hold_wr_en",    32'(wr_en),    32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    // prob < 0 toggles in_valid every cycle; abort_at >= 0 resets once that many bytes are in.
    task automatic run_load(input int l, input int prob, input int abort_at, input bit stray);
        int cyc;
        bit tog;
        int exp_writes;
        cyc        = 0;
        tog        = 1'b0;
        obs_writes = 0;
        obs_dones  = 0;
        exp_writes = (l > DEPTH_TB) ? DEPTH_TB : l;
        start    = 1'b1;
        len      = 10'(l);
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        step();
        start = 1'b0;
        while ((m_active || m_done) && cyc < BOUND) begin
            if (abort_at >= 0 && m_bytes == abort_at && !m_wen) begin
                apply_reset();
                return;
            end
            if (prob < 0) begin
                tog      = !tog;
                in_valid = tog;
            end else begin
                in_valid = ($urandom_range(99) < prob);
            end
            in_data = 8'($urandom);
            if (stray && cyc == 3) begin
                start = 1'b1;
                len   = 10'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (cyc >= BOUND) check("load_timeout", 32'd1, 32'd0);
        check("write_count", 32'(obs_writes), 32'(exp_writes));
        check("done_pulses", 32'(obs_dones), 32'd1);
    endtask

    initial begin
        logic [7:0] bytes_q [4];
        int cyc;
        bytes_q[0] = 8'h13;
        bytes_q[1] = 8'h00;
        bytes_q[2] = 8'h10;
        bytes_q[3] = 8'h00;

        #1;
        apply_reset();
        repeat (2) step();

        // Single word, back-to-back bytes.
        obs_writes = 0;
        obs_dones  = 0;
        start = 1'b1;
        len   = 10'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bytes_q[i];
            step();
        end
        in_valid = 1'b0;
        cyc = 0;
        while ((m_active || m_done) && cyc < 10) begin
            step();
            cyc++;
        end
        check("one_word_data",  obs_last_data, 32'h0010_0013);
        check("one_word_addr",  32'(obs_last_addr), 32'd0);
        check("one_word_count", 32'(obs_writes), 32'd1);
        check("one_word_done",  32'(obs_dones), 32'd1);
        check("one_word_idle",  32'(busy), 32'd0);

        run_load(3, -1, -1, 1'b0);
        run_load(0, 100, -1, 1'b0);
        repeat (2) step();

        run_load(600, 90, -1, 1'b0);
        check("full_last_addr", 32'(obs_last_addr), 32'd511);

        // Reset two bytes into word 5, then reload from address 0.
        run_load(8, 70, 22, 1'b0);
        run_load(2, 80, -1, 1'b0);
        check("reload_last_addr", 32'(obs_last_addr), 32'd1);

        // in_valid high while idle, then a stray start mid-load.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) step();
        in_valid = 1'b0;
        run_load(5, 60, -1, 1'b1);

        for (int k = 0; k < 10; k++) begin
            run_load(int'($urandom_range(40)), int'($urandom_range(100, 30)), -1, 1'($urandom));
            repeat (int'($urandom_range(3))) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
